round_controller: RTL and testbench
===================================

// Module: round_controller
// PURPOSE
//  Game-flow state machine for one Duck Hunt session. Drives the 3-bit game state that the
//  shot counter gates on (PLAY = 3'b010), consumes its no_shots_left flag and the duck hit
//  flag, and sequences launch / flight / hit / fly-away / round-end / game-over on frame ticks.
//  Owns ducks-hit, duck index, round number and score. Feeds the shot counter's clear and the HUD.
// PARAMETERS
//  DUCKS_PER_ROUND  10   ducks launched per round
//  MIN_HITS         6    hits needed in a round to advance; fewer -> GAME_OVER
//  LAUNCH_FRAMES    60   frame ticks spent in LAUNCH
//  FLIGHT_FRAMES    300  max frame ticks in PLAY before forced fly-away
//  FALL_FRAMES      45   frame ticks spent in HIT (duck falling)
//  FLYAWAY_FRAMES   60   frame ticks spent in FLYAWAY
//  POINTS_PER_HIT   500  score added per hit
// PORTS
//  Clk            in   1   system clock
//  Reset_n        in   1   asynchronous, active-low reset
//  start          in   1   start/continue button, level; rising edge detected internally
//  frame_tick     in   1   one-cycle pulse per video frame (vsync)
//  duck_hit       in   1   level; shot landed on duck this cycle (only sampled in PLAY)
//  no_shots_left  in   1   from shot counter; 1 when 3 shots used
//  state          out  3   registered game state (encoding below)
//  shots_clear    out  1   one-cycle pulse in first LAUNCH cycle; resets shot counter
//  ducks_hit      out  4   hits so far in current round
//  duck_idx       out  4   ducks completed in current round
//  round_num      out  8   current round, starts at 1, saturates at 255
//  score          out  20  total score, saturates at 20'hFFFFF
//  game_over      out  1   1 while state == GAME_OVER
// BEHAVIOUR
//  Encoding: IDLE 000, LAUNCH 001, PLAY 010, HIT 011, FLYAWAY 100, ROUND_END 101, GAME_OVER 110.
//  Reset (async, Reset_n=0): state=IDLE, shots_clear=0, ducks_hit=0, duck_idx=0, round_num=1,
//   score=0, game_over=0, frame counter=0, start edge register=0. All outputs registered.
//  Start edge: start_edge = start & ~start_q; start_q sampled each cycle.
//  Frame counter: cleared on every state change; +1 on frame_tick. "Expire(N)" = frame_tick
//   while counter == N-1; transition takes effect next Clk edge (1-cycle latency).
//  IDLE: start_edge -> LAUNCH.
//  LAUNCH: shots_clear=1 on entry cycle only. Expire(LAUNCH_FRAMES) -> PLAY.
//  PLAY: priority duck_hit > no_shots_left > Expire(FLIGHT_FRAMES).
//   duck_hit -> HIT; ducks_hit+1, score+POINTS_PER_HIT (saturating) on the same edge.
//   no_shots_left or flight expiry -> FLYAWAY. Hit and no_shots_left same cycle: HIT.
//  HIT: Expire(FALL_FRAMES) -> ROUND_END. FLYAWAY: Expire(FLYAWAY_FRAMES) -> ROUND_END.
//   duck_hit / no_shots_left ignored outside PLAY.
//  ROUND_END (exactly 1 cycle): let n = duck_idx+1.
//   n < DUCKS_PER_ROUND -> duck_idx=n, LAUNCH.
//   n == DUCKS_PER_ROUND and ducks_hit >= MIN_HITS -> duck_idx=0, ducks_hit=0,
//    round_num+1 (saturate), LAUNCH.
//   n == DUCKS_PER_ROUND and ducks_hit < MIN_HITS -> GAME_OVER (counters held for HUD).
//  GAME_OVER: game_over=1. start_edge -> IDLE, clearing ducks_hit, duck_idx, score, round_num=1.
//  start_edge outside IDLE/GAME_OVER ignored. frame_tick and state change never double-count.
//  Reset asserted mid-operation: immediate return to reset values; no pulse on shots_clear.
// STRUCTURE
//  duck_pkg: typedef enum logic [2:0] game_state_t (values above), POINTS_PER_HIT default,
//   score/round widths. Shared with shot counter and sprite/HUD logic.
//  Sub-module frame_timer (counter, clear, tick, terminal compare -> expire); FSM + stats inline.
// TESTING  (bench uses small params: LAUNCH=2, FLIGHT=5, FALL=2, FLYAWAY=2, DUCKS=3, MIN_HITS=2)
//  Reset_n low mid-PLAY -> state=000, score=0, round_num=1 asynchronously, before next Clk edge.
//  start pulse, 2 ticks -> LAUNCH with 1-cycle shots_clear, then state=010 after 2nd tick.
//  In PLAY assert duck_hit and no_shots_left same cycle -> state=011, ducks_hit=1, score=500.
//  PLAY, no input, 5 ticks -> FLYAWAY; 2 ticks -> ROUND_END 1 cycle -> LAUNCH, duck_idx=1.
//  3 ducks, 2 hits -> round_num=2, ducks_hit=0, duck_idx=0; 3 ducks, 1 hit -> GAME_OVER, game_over=1.
//  GAME_OVER + start edge -> IDLE, score=0; holding start high gives no second launch.

Source files
------------

// File: rtl/duck_pkg.sv
// Shared Duck Hunt types and constants: game state encoding, score/round widths
// and helpers used by the round controller, shot counter and HUD.
package duck_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_LAUNCH    = 3'b001,
    ST_PLAY      = 3'b010,
    ST_HIT       = 3'b011,
    ST_FLYAWAY   = 3'b100,
    ST_ROUND_END = 3'b101,
    ST_GAME_OVER = 3'b110
  } game_state_t;

  localparam int POINTS_PER_HIT = 500;
  localparam int SCORE_W        = 20;
  localparam int ROUND_W        = 8;
  localparam int COUNT_W        = 4;

  function automatic int maxFrames(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame tick counter for timed game phases; expire_o fires on the tick that
// reaches the terminal count so the owner can leave the phase on that edge.
module frame_timer #(
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         clear_i,
  input  logic         tick_i,
  input  logic [W-1:0] terminal_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = tick_i && (cnt_q == terminal_i);

  // A clear wins over a simultaneous tick so a phase change never double-counts.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)     cnt_d = '0;
    else if (tick_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/round_controller.sv
// Duck Hunt game-flow FSM: sequences launch/flight/hit/fly-away/round-end/game-over
// on frame ticks and keeps the per-round and session statistics for the HUD.
module round_controller
  import duck_pkg::*;
#(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int MIN_HITS        = 6,
  parameter int LAUNCH_FRAMES   = 60,
  parameter int FLIGHT_FRAMES   = 300,
  parameter int FALL_FRAMES     = 45,
  parameter int FLYAWAY_FRAMES  = 60,
  parameter int POINTS_PER_HIT  = duck_pkg::POINTS_PER_HIT
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               duck_hit,
  input  logic               no_shots_left,
  output logic [2:0]         state,
  output logic               shots_clear,
  output logic [COUNT_W-1:0] ducks_hit,
  output logic [COUNT_W-1:0] duck_idx,
  output logic [ROUND_W-1:0] round_num,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  localparam int MAX_FRAMES = maxFrames(LAUNCH_FRAMES, FLIGHT_FRAMES, FALL_FRAMES, FLYAWAY_FRAMES);
  localparam int TIMER_W    = $clog2(MAX_FRAMES) + 1;
  localparam int SUM_W      = SCORE_W + 1;

  game_state_t        state_q, state_d;
  logic               start_q;
  logic               shots_clear_q, shots_clear_d;
  logic               game_over_q, game_over_d;
  logic [COUNT_W-1:0] ducks_hit_q, ducks_hit_d;
  logic [COUNT_W-1:0] duck_idx_q, duck_idx_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [SCORE_W-1:0] score_q, score_d;

  logic               start_edge;
  logic               expire;
  logic [TIMER_W-1:0] terminal;
  logic [SUM_W-1:0]   score_sum;
  logic [COUNT_W-1:0] duck_next;

  assign start_edge = start && !start_q;
  assign score_sum  = {1'b0, score_q} + SUM_W'(POINTS_PER_HIT);
  assign duck_next  = duck_idx_q + COUNT_W'(1);

  always_comb begin
    terminal = '1;
    case (state_q)
      ST_LAUNCH:  terminal = TIMER_W'(LAUNCH_FRAMES - 1);
      ST_PLAY:    terminal = TIMER_W'(FLIGHT_FRAMES - 1);
      ST_HIT:     terminal = TIMER_W'(FALL_FRAMES - 1);
      ST_FLYAWAY: terminal = TIMER_W'(FLYAWAY_FRAMES - 1);
      default:    terminal = '1;
    endcase
  end

  frame_timer #(.W(TIMER_W)) u_frame_timer (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .clear_i    (state_d != state_q),
    .tick_i     (frame_tick),
    .terminal_i (terminal),
    .expire_o   (expire)
  );

  always_comb begin
    state_d     = state_q;
    ducks_hit_d = ducks_hit_q;
    duck_idx_d  = duck_idx_q;
    round_d     = round_q;
    score_d     = score_q;
    case (state_q)
      ST_IDLE:
        if (start_edge) state_d = ST_LAUNCH;
      ST_LAUNCH:
        if (expire) state_d = ST_PLAY;
      ST_PLAY: begin
        if (duck_hit) begin
          state_d = ST_HIT;
          if (ducks_hit_q != '1) ducks_hit_d = ducks_hit_q + COUNT_W'(1);
          score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end else if (no_shots_left || expire) begin
          state_d = ST_FLYAWAY;
        end
      end
      ST_HIT, ST_FLYAWAY:
        if (expire) state_d = ST_ROUND_END;
      ST_ROUND_END: begin
        if (duck_next < COUNT_W'(DUCKS_PER_ROUND)) begin
          duck_idx_d = duck_next;
          state_d    = ST_LAUNCH;
        end else if (ducks_hit_q >= COUNT_W'(MIN_HITS)) begin
          duck_idx_d  = '0;
          ducks_hit_d = '0;
          if (round_q != '1) round_d = round_q + ROUND_W'(1);
          state_d     = ST_LAUNCH;
        end else begin
          state_d = ST_GAME_OVER;
        end
      end
      ST_GAME_OVER: begin
        if (start_edge) begin
          state_d     = ST_IDLE;
          ducks_hit_d = '0;
          duck_idx_d  = '0;
          score_d     = '0;
          round_d     = ROUND_W'(1);
        end
      end
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Flags are registered from the next state so they line up with the state output.
  assign shots_clear_d = (state_d == ST_LAUNCH) && (state_q != ST_LAUNCH);
  assign game_over_d   = (state_d == ST_GAME_OVER);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= ST_IDLE;
      start_q       <= 1'b0;
      shots_clear_q <= 1'b0;
      game_over_q   <= 1'b0;
      ducks_hit_q   <= '0;
      duck_idx_q    <= '0;
      round_q       <= ROUND_W'(1);
      score_q       <= '0;
    end else begin
      state_q       <= state_d;
      start_q       <= start;
      shots_clear_q <= shots_clear_d;
      game_over_q   <= game_over_d;
      ducks_hit_q   <= ducks_hit_d;
      duck_idx_q    <= duck_idx_d;
      round_q       <= round_d;
      score_q       <= score_d;
    end
  end

  assign state       = state_q;
  assign shots_clear = shots_clear_q;
  assign game_over   = game_over_q;
  assign ducks_hit   = ducks_hit_q;
  assign duck_idx    = duck_idx_q;
  assign round_num   = round_q;
  assign score       = score_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: directed game flow followed by
// randomized stimulus, compared every cycle against a phase/countdown model.
module tb_round_controller;

  localparam int DUCKS   = 3;
  localparam int MINHITS = 2;
  localparam int LAUNCHF = 2;
  localparam int FLIGHTF = 5;
  localparam int FALLF   = 2;
  localparam int FLYF    = 2;
  localparam int POINTS  = 500;
  localparam int SCOREMAX = 20'hFFFFF;

  localparam int P_IDLE = 0, P_LAUNCH = 1, P_PLAY = 2, P_HIT = 3,
                 P_FLYAWAY = 4, P_ROUND_END = 5, P_GAME_OVER = 6;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0, frame_tick = 1'b0, duck_hit = 1'b0, no_shots_left = 1'b0;
  logic [2:0]  state;
  logic        shots_clear, game_over;
  logic [3:0]  ducks_hit, duck_idx;
  logic [7:0]  round_num;
  logic [19:0] score;

  int checkCount = 0;
  int errorCount = 0;

  int mPhase, mTicksLeft, mDucksHit, mDuckIdx, mRound, mScore;
  bit mShotsClear, mStartPrev;

  round_controller #(
    .DUCKS_PER_ROUND(DUCKS), .MIN_HITS(MINHITS), .LAUNCH_FRAMES(LAUNCHF),
    .FLIGHT_FRAMES(FLIGHTF), .FALL_FRAMES(FALLF), .FLYAWAY_FRAMES(FLYF),
    .POINTS_PER_HIT(POINTS)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .frame_tick(frame_tick),
    .duck_hit(duck_hit), .no_shots_left(no_shots_left), .state(state),
    .shots_clear(shots_clear), .ducks_hit(ducks_hit), .duck_idx(duck_idx),
    .round_num(round_num), .score(score), .game_over(game_over)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int framesFor(input int phase);
    case (phase)
      P_LAUNCH:  return LAUNCHF;
      P_PLAY:    return FLIGHTF;
      P_HIT:     return FALLF;
      P_FLYAWAY: return FLYF;
      default:   return 0;
    endcase
  endfunction

  task automatic modelReset();
    mPhase = P_IDLE; mTicksLeft = 0; mDucksHit = 0; mDuckIdx = 0;
    mRound = 1; mScore = 0; mShotsClear = 0; mStartPrev = 0;
  endtask

  // Timed phases are modelled as "ticks remaining", reloaded on every phase entry.
  task automatic modelStep(input bit s, input bit t, input bit h, input bit n);
    int nextPhase;
    bit pressed;
    pressed = s && !mStartPrev;
    mStartPrev = s;
    nextPhase = mPhase;
    case (mPhase)
      P_IDLE: if (pressed) nextPhase = P_LAUNCH;
      P_LAUNCH, P_HIT, P_FLYAWAY:
        if (t) begin
          if (mTicksLeft == 1) nextPhase = (mPhase == P_LAUNCH) ? P_PLAY : P_ROUND_END;
          else mTicksLeft--;
        end
      P_PLAY:
        if (h) begin
          nextPhase = P_HIT;
          mDucksHit++;
          mScore = (mScore + POINTS > SCOREMAX) ? SCOREMAX : mScore + POINTS;
        end else if (n) nextPhase = P_FLYAWAY;
        else if (t) begin
          if (mTicksLeft == 1) nextPhase = P_FLYAWAY;
          else mTicksLeft--;
        end
      P_ROUND_END:
        if (mDuckIdx + 1 < DUCKS) begin
          mDuckIdx++; nextPhase = P_LAUNCH;
        end else if (mDucksHit >= MINHITS) begin
          mDuckIdx = 0; mDucksHit = 0; mRound = (mRound < 255) ? mRound + 1 : 255;
          nextPhase = P_LAUNCH;
        end else nextPhase = P_GAME_OVER;
      P_GAME_OVER:
        if (pressed) begin
          nextPhase = P_IDLE; mDucksHit = 0; mDuckIdx = 0; mScore = 0; mRound = 1;
        end
      default: nextPhase = P_IDLE;
    endcase
    mShotsClear = (nextPhase == P_LAUNCH) && (mPhase != P_LAUNCH);
    if (nextPhase != mPhase) mTicksLeft = framesFor(nextPhase);
    mPhase = nextPhase;
  endtask

  task automatic checkAll();
    checkOutput("state", 32'(state), 32'(mPhase));
    checkOutput("shots_clear", 32'(shots_clear), 32'(mShotsClear));
    checkOutput("ducks_hit", 32'(ducks_hit), 32'(mDucksHit));
    checkOutput("duck_idx", 32'(duck_idx), 32'(mDuckIdx));
    checkOutput("round_num", 32'(round_num), 32'(mRound));
    checkOutput("score", 32'(score), 32'(mScore));
    checkOutput("game_over", 32'(game_over), 32'(mPhase == P_GAME_OVER));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
  task automatic applyStimulus(input bit s, input bit t, input bit h, input bit n);
    start = s; frame_tick = t; duck_hit = h; no_shots_left = n;
    @(posedge Clk);
    modelStep(s, t, h, n);
    @(negedge Clk);
    checkAll();
  endtask

  task automatic ticks(input int count);
    for (int i = 0; i < count; i++) applyStimulus(0, 1, 0, 0);
  endtask

  task automatic applyReset();
    Reset_n = 1'b0;
    modelReset();
    @(negedge Clk);
    Reset_n = 1'b1;
    checkAll();
  endtask

  initial begin
    modelReset();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    checkAll();
    checkOutput("reset_round", 32'(round_num), 32'd1);

    applyStimulus(1, 0, 0, 0);
    checkOutput("launch_state", 32'(state), 32'd1);
    checkOutput("launch_clear", 32'(shots_clear), 32'd1);
    ticks(1);
    checkOutput("clear_pulse_len", 32'(shots_clear), 32'd0);
    checkOutput("launch_hold", 32'(state), 32'd1);
    ticks(1);
    checkOutput("play_state", 32'(state), 32'd2);

    applyStimulus(0, 0, 1, 1);
    checkOutput("hit_prio_state", 32'(state), 32'd3);
    checkOutput("hit_ducks", 32'(ducks_hit), 32'd1);
    checkOutput("hit_score", 32'(score), 32'd500);
    ticks(2);
    checkOutput("round_end_hit", 32'(state), 32'd5);
    applyStimulus(0, 0, 0, 0);
    checkOutput("next_duck_idx", 32'(duck_idx), 32'd1);

    ticks(2);
    ticks(5);
    checkOutput("flight_expire", 32'(state), 32'd4);
    ticks(2);
    checkOutput("round_end_fly", 32'(state), 32'd5);
    applyStimulus(0, 0, 0, 0);
    checkOutput("relaunch", 32'(state), 32'd1);
    checkOutput("duck_idx_2", 32'(duck_idx), 32'd2);

    ticks(2); applyStimulus(0, 0, 1, 0); ticks(2); applyStimulus(0, 0, 0, 0);
    checkOutput("round_adv", 32'(round_num), 32'd2);
    checkOutput("round_ducks_clr", 32'(ducks_hit), 32'd0);
    checkOutput("round_idx_clr", 32'(duck_idx), 32'd0);

    ticks(2); applyStimulus(0, 0, 1, 0); ticks(2); applyStimulus(0, 0, 0, 0);
    for (int d = 0; d < 2; d++) begin
      ticks(2); applyStimulus(0, 0, 0, 1); ticks(2); applyStimulus(0, 0, 0, 0);
    end
    checkOutput("go_state", 32'(state), 32'd6);
    checkOutput("go_flag", 32'(game_over), 32'd1);
    checkOutput("go_score_held", 32'(score), 32'd1500);

    applyStimulus(1, 0, 0, 0);
    checkOutput("go_to_idle", 32'(state), 32'd0);
    checkOutput("go_score_clr", 32'(score), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("held_start_idle", 32'(state), 32'd0);

    applyStimulus(0, 0, 0, 0); applyStimulus(1, 0, 0, 0); ticks(2);
    applyStimulus(0, 0, 1, 0); ticks(2); applyStimulus(0, 0, 0, 0); ticks(2);
    checkOutput("pre_reset_play", 32'(state), 32'd2);
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("async_state", 32'(state), 32'd0);
    checkOutput("async_score", 32'(score), 32'd0);
    checkOutput("async_round", 32'(round_num), 32'd1);
    checkOutput("async_clear", 32'(shots_clear), 32'd0);
    applyReset();

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(499) == 0) applyReset();
      else applyStimulus($urandom_range(19) == 0, $urandom_range(9) < 4,
                         $urandom_range(19) == 0, $urandom_range(19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
